// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, synchronous IMEM request, IF/ID register
// with a one-entry skid buffer, and redirect squash.
// Optional macro IF_MISALIGN_TRAP_EN: misaligned redirect targets raise a
// sticky MISALIGN flag and stop fetch; otherwise targets are word-aligned.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        IF_CLK,
    input  logic        IF_RST_N,
    input  logic [1:0]  PC_SOURCE,
    input  logic [31:0] JALR,
    input  logic [31:0] BRANCH,
    input  logic [31:0] JAL,
    input  logic        STALL,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_RD_EN,
    input  logic [31:0] IMEM_DOUT,
    output logic [31:0] IR,
    output logic [31:0] PC_COUNT,
    output logic        IF_VALID,
    output logic        FLUSH,
    output logic        MISALIGN
);

    logic [31:0] pc_q, req_pc, skid_ir, skid_pc;
    logic [31:0] raw_tgt, target;
    logic        req_v, skid_v;
    logic        redirect, trap_hit, trapped, issue;

    assign redirect = (PC_SOURCE != 2'b00);

    // Redirect target select; JALR drops bit 0 like the ISA requires
    always_comb begin
        raw_tgt = pc_q;
        case (PC_SOURCE)
            2'b01:   raw_tgt = JALR & ~32'h1;
            2'b10:   raw_tgt = BRANCH;
            2'b11:   raw_tgt = JAL;
            default: raw_tgt = pc_q;
        endcase
    end

`ifdef IF_MISALIGN_TRAP_EN
    assign target   = raw_tgt;
    assign trap_hit = redirect && (raw_tgt[1:0] != 2'b00);
    assign trapped  = MISALIGN;

    // Sticky misalign flag, cleared only by reset
    always_ff @(posedge IF_CLK or negedge IF_RST_N) begin
        if (!IF_RST_N)
            MISALIGN <= 1'b0;
        else if (trap_hit)
            MISALIGN <= 1'b1;
    end
`else
    assign target   = raw_tgt & 32'hFFFF_FFFC;
    assign trap_hit = 1'b0;
    assign trapped  = 1'b0;
    assign MISALIGN = 1'b0;
`endif

    // No request while redirecting, stalled, or trapped; memory address is the fetch PC
    assign issue      = !redirect && !STALL && !trapped;
    assign IMEM_RD_EN = issue;
    assign IMEM_ADDR  = pc_q;

    // Fetch PC, in-flight request, skid buffer and IF/ID register
    always_ff @(posedge IF_CLK or negedge IF_RST_N) begin
        if (!IF_RST_N) begin
            pc_q     <= RESET_PC;
            req_v    <= 1'b0;
            req_pc   <= 32'h0;
            skid_v   <= 1'b0;
            skid_ir  <= 32'h0;
            skid_pc  <= 32'h0;
            IR       <= 32'h0;
            PC_COUNT <= 32'h0;
            IF_VALID <= 1'b0;
            FLUSH    <= 1'b0;
        end else if (redirect) begin
            // Squash everything younger, even under STALL; a trapping
            // target leaves the PC frozen
            if (!trapped && !trap_hit)
                pc_q <= target;
            req_v    <= 1'b0;
            skid_v   <= 1'b0;
            IF_VALID <= 1'b0;
            FLUSH    <= 1'b1;
        end else begin
            FLUSH <= 1'b0;
            if (issue) begin
                req_pc <= pc_q;
                req_v  <= 1'b1;
                pc_q   <= pc_q + 32'd4;
            end else begin
                req_v  <= 1'b0;
            end
            if (!STALL) begin
                // Skid holds the older word, so it drains first
                if (skid_v) begin
                    IR       <= skid_ir;
                    PC_COUNT <= skid_pc;
                    IF_VALID <= 1'b1;
                    skid_v   <= 1'b0;
                end else if (req_v) begin
                    IR       <= IMEM_DOUT;
                    PC_COUNT <= req_pc;
                    IF_VALID <= 1'b1;
                end else begin
                    IF_VALID <= 1'b0;
                end
                if (trapped)
                    IF_VALID <= 1'b0;
            end else if (req_v) begin
                // Memory word arriving during a stall parks in the skid
                skid_ir <= IMEM_DOUT;
                skid_pc <= req_pc;
                skid_v  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_fetch_stage;

    logic        IF_CLK = 1'b0;
    logic        IF_RST_N;
    logic [1:0]  PC_SOURCE;
    logic [31:0] JALR, BRANCH, JAL;
    logic        STALL;
    logic [31:0] IMEM_ADDR, IMEM_DOUT, IR, PC_COUNT;
    logic        IMEM_RD_EN, IF_VALID, FLUSH, MISALIGN;

    logic [31:0] addr2, dout2, ir2, pc2;
    logic        rd2, v2, fl2, mis2;

    int errors = 0;
    int checks = 0;

    always #5 IF_CLK = ~IF_CLK;

    fetch_stage dut (
        .IF_CLK(IF_CLK), .IF_RST_N(IF_RST_N), .PC_SOURCE(PC_SOURCE),
        .JALR(JALR), .BRANCH(BRANCH), .JAL(JAL), .STALL(STALL),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_RD_EN(IMEM_RD_EN), .IMEM_DOUT(IMEM_DOUT),
        .IR(IR), .PC_COUNT(PC_COUNT), .IF_VALID(IF_VALID), .FLUSH(FLUSH),
        .MISALIGN(MISALIGN)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .IF_CLK(IF_CLK), .IF_RST_N(IF_RST_N), .PC_SOURCE(2'b00),
        .JALR(32'h0), .BRANCH(32'h0), .JAL(32'h0), .STALL(1'b0),
        .IMEM_ADDR(addr2), .IMEM_RD_EN(rd2), .IMEM_DOUT(dout2),
        .IR(ir2), .PC_COUNT(pc2), .IF_VALID(v2), .FLUSH(fl2),
        .MISALIGN(mis2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ 32'h5A00_0000;
    endfunction

    // Synchronous instruction memories, one-cycle read latency
    always @(posedge IF_CLK) begin
        if (IMEM_RD_EN) IMEM_DOUT <= mem_word(IMEM_ADDR);
        if (rd2)        dout2     <= mem_word(addr2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched-but-undelivered PCs
    logic [31:0] pend[$];
    logic [31:0] m_fpc, m_pc, m_tgt;
    logic        m_valid, m_flush, m_mis;

    always @(posedge IF_CLK or negedge IF_RST_N) begin
        if (!IF_RST_N) begin
            pend.delete();
            m_fpc = 32'h0; m_pc = 32'h0;
            m_valid = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
        end else if (PC_SOURCE != 2'b00) begin
            case (PC_SOURCE)
                2'b01:   m_tgt = {JALR[31:1], 1'b0};
                2'b10:   m_tgt = BRANCH;
                default: m_tgt = JAL;
            endcase
            pend.delete();
            m_valid = 1'b0;
            m_flush = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
            if (m_tgt[1:0] != 2'b00) m_mis = 1'b1;
            if (!m_mis) m_fpc = m_tgt;
`else
            m_fpc = {m_tgt[31:2], 2'b00};
`endif
        end else begin
            m_flush = 1'b0;
            if (!STALL) begin
                if (pend.size() > 0) begin
                    m_pc = pend.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
                if (!m_mis) begin
                    pend.push_back(m_fpc);
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    end

    // Compare process, mid-cycle
    always @(negedge IF_CLK) begin
        if (IF_RST_N) begin
            chk("if_valid", {31'h0, IF_VALID}, {31'h0, m_valid});
            chk("flush", {31'h0, FLUSH}, {31'h0, m_flush});
            chk("misalign", {31'h0, MISALIGN}, {31'h0, m_mis});
            chk("imem_addr", IMEM_ADDR, m_fpc);
            chk("imem_rd_en", {31'h0, IMEM_RD_EN},
                {31'h0, (PC_SOURCE == 2'b00) && !STALL && !m_mis});
            if (m_valid) begin
                chk("pc_count", PC_COUNT, m_pc);
                chk("ir", IR, mem_word(m_pc));
            end
        end
    end

    task automatic step();
        @(posedge IF_CLK);
        #2;
    endtask

    initial begin
        IF_RST_N = 1'b0; PC_SOURCE = 2'b00; STALL = 1'b0;
        JALR = 32'h0; BRANCH = 32'h0; JAL = 32'h0;
        repeat (2) @(posedge IF_CLK);
        #2;
        chk("rst_valid", {31'h0, IF_VALID}, 32'h0);
        chk("rst_ir", IR, 32'h0);
        chk("rst_pc", PC_COUNT, 32'h0);
        chk("rst_flush", {31'h0, FLUSH}, 32'h0);
        chk("rst_mis", {31'h0, MISALIGN}, 32'h0);
        chk("rst_addr", IMEM_ADDR, 32'h0);
        chk("rst_addr2", addr2, 32'hFFFF_FFF8);
        IF_RST_N = 1'b1;

        // Streaming fetch after reset
        step(); chk("t1_e1_valid", {31'h0, IF_VALID}, 32'h0);
        step(); chk("t1_pc0", PC_COUNT, 32'h0); chk("t1_ir0", IR, 32'h5A00_0000);
        chk("t5_pc0", pc2, 32'hFFFF_FFF8); chk("t5_v0", {31'h0, v2}, 32'h1);
        step(); chk("t1_pc4", PC_COUNT, 32'h4);
        chk("t5_pc1", pc2, 32'hFFFF_FFFC);
        step(); chk("t1_pc8", PC_COUNT, 32'h8); chk("t1_ir8", IR, 32'h5A00_0002);
        chk("t5_pc2", pc2, 32'h0000_0000); chk("t5_ir2", ir2, 32'h5A00_0000);

        // Stall three cycles holding PC 8
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("t2_hold_pc", PC_COUNT, 32'h8); chk("t2_hold_v", {31'h0, IF_VALID}, 32'h1);
        end
        STALL = 1'b0;
        step(); chk("t2_pc12", PC_COUNT, 32'hC); chk("t2_ir12", IR, 32'h5A00_0003);
        step(); chk("t2_pc16", PC_COUNT, 32'h10);

        // JAL redirect when PC_COUNT reaches 0x20
        for (int i = 0; i < 20 && !(IF_VALID && PC_COUNT == 32'h20); i++) step();
        chk("t3_reach20", PC_COUNT, 32'h20);
        PC_SOURCE = 2'b11; JAL = 32'h100;
        step(); PC_SOURCE = 2'b00;
        chk("t3_flush", {31'h0, FLUSH}, 32'h1); chk("t3_b1", {31'h0, IF_VALID}, 32'h0);
        step(); chk("t3_flush0", {31'h0, FLUSH}, 32'h0); chk("t3_b2", {31'h0, IF_VALID}, 32'h0);
        step(); chk("t3_pc100", PC_COUNT, 32'h100); chk("t3_v", {31'h0, IF_VALID}, 32'h1);

        // JALR clears bit 0
        PC_SOURCE = 2'b01; JALR = 32'h201;
        step(); PC_SOURCE = 2'b00;
        step(); step(); chk("t3_pc200", PC_COUNT, 32'h200);

        // Branch while stalled with a full skid
        STALL = 1'b1;
        step(); step();
        PC_SOURCE = 2'b10; BRANCH = 32'h40;
        step(); PC_SOURCE = 2'b00; STALL = 1'b0;
        chk("t4_flush", {31'h0, FLUSH}, 32'h1); chk("t4_v", {31'h0, IF_VALID}, 32'h0);
        step(); chk("t4_b2", {31'h0, IF_VALID}, 32'h0);
        step(); chk("t4_pc40", PC_COUNT, 32'h40);

        // Misaligned branch target
        PC_SOURCE = 2'b10; BRANCH = 32'h42;
        step(); PC_SOURCE = 2'b00;
        chk("t6_flush", {31'h0, FLUSH}, 32'h1);
        step(); step();
`ifdef IF_MISALIGN_TRAP_EN
        chk("t6_mis", {31'h0, MISALIGN}, 32'h1);
        chk("t6_rd", {31'h0, IMEM_RD_EN}, 32'h0);
        chk("t6_v", {31'h0, IF_VALID}, 32'h0);
        step(); step();
        chk("t6_mis_sticky", {31'h0, MISALIGN}, 32'h1);
`else
        chk("t6_pc40", PC_COUNT, 32'h40);
        chk("t6_mis0", {31'h0, MISALIGN}, 32'h0);
`endif

        // Mixed stalls and one redirect, checked by the model only
        for (int i = 0; i < 40; i++) begin
            STALL = 1'($urandom_range(0, 1));
            PC_SOURCE = (i == 20) ? 2'b11 : 2'b00;
            JAL = 32'h800;
            step();
        end
        STALL = 1'b0; PC_SOURCE = 2'b00;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
